// File: rtl/write_cal.sv
// write_cal: binary-to-BCD converter with a multiplexed 8-digit display.
//
// A 32-bit value is turned into 10 packed BCD digits by double-dabble,
// one iteration per clock, 32 clocks per conversion. The lower 8 digits
// of the last result are scanned onto a common-anode 7-segment display.
// Leading zeros are blanked. Results that need more than 8 digits show
// "-" on every digit.
//
// Ports
//   clk    : sole clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : request conversion of value (accepted only while idle)
//   value  : 32-bit unsigned operand, sampled on the accepting edge
//   busy   : conversion in progress
//   done   : one-cycle pulse, bcd/ovf just updated
//   bcd    : 10 packed BCD digits of the last result, bcd[3:0] = units
//   ovf    : last result >= 100_000_000
//   an     : active-low digit enables, an[0] = units
//   seg    : active-low segments {g,f,e,d,c,b,a}
module write_cal #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] value,
   output logic        busy,
   output logic        done,
   output logic [39:0] bcd,
   output logic        ovf,
   output logic [7:0]  an,
   output logic [6:0]  seg
);

   localparam int CW = $clog2(SCAN_DIV);

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   // conversion state
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] shift_q, shift_d;
   logic [39:0] work_q, work_d;
   logic [39:0] bcd_q, bcd_d;
   logic        ovf_q, ovf_d;

   // display state
   logic [CW-1:0] scan_q, scan_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   logic [39:0] adj;
   logic [39:0] work_sh;
   logic [31:0] shift_sh;
   logic [3:0]  dig;
   logic        allz;
   logic        blank;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // double-dabble step: correct digits >= 5 so the shift carries into
   // the next digit instead of producing 10..15
   always_comb begin
      adj = '0;
      for (int d = 0; d < 10; d++) begin
         if (work_q[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
         else
            adj[4*d +: 4] = work_q[4*d +: 4];
      end
      work_sh  = {adj[38:0], shift_q[31]};
      shift_sh = {shift_q[30:0], 1'b0};
   end

   always_comb begin
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      work_d  = work_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      if (busy_q) begin
         work_d  = work_sh;
         shift_d = shift_sh;
         cnt_d   = cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            bcd_d  = work_sh;
            ovf_d  = |work_sh[39:32];
         end
      end else if (start) begin
         shift_d = value;
         work_d  = '0;
         busy_d  = 1'b1;
         cnt_d   = '0;
      end
   end

   // display scan; an/seg are computed from next-state so the registered
   // outputs always agree with the current digit index and result
   always_comb begin
      if (scan_q == CW'(SCAN_DIV - 1)) begin
         scan_d = '0;
         idx_d  = idx_q + 3'd1;
      end else begin
         scan_d = scan_q + CW'(1);
         idx_d  = idx_q;
      end

      dig   = bcd_d[4*idx_d +: 4];
      allz  = 1'b1;
      blank = 1'b0;
      // walk from the top display digit down; a digit is blank when it and
      // everything above it is zero
      for (int k = 7; k >= 0; k--) begin
         allz = allz & (bcd_d[4*k +: 4] == 4'd0);
         if ((3'(k) == idx_d) && (k != 0))
            blank = allz;
      end

      an_d = ~(8'b1 << idx_d);
      if (ovf_d)
         seg_d = SEG_DASH;
      else if (blank)
         seg_d = SEG_BLANK;
      else
         seg_d = seg7(dig);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         shift_q <= '0;
         work_q  <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         scan_q  <= '0;
         idx_q   <= '0;
         an_q    <= 8'hFE;
         seg_q   <= SEG_ZERO;
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         work_q  <= work_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;
   assign an   = an_q;
   assign seg  = seg_q;

endmodule

// File: tb/tb_write_cal.sv
// Directed bench for write_cal: table of conversions plus hand-written
// sequences for busy-ignore, reset abort, back-to-back start and display.
module tb_write_cal;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] value = '0;
   logic        busy, done, ovf;
   logic [39:0] bcd;
   logic [7:0]  an;
   logic [6:0]  seg;

   int total = 0;
   int bad   = 0;

   logic [39:0] prev_bcd = '0;
   logic        prev_ovf = 1'b0;

   write_cal #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .value(value),
      .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] v;
      logic [39:0] b;
      logic        o;
   } vec_t;

   vec_t tbl [10];
   logic [6:0] e1205 [8];

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   // start one conversion, return done latency in cycles after the
   // accepting edge; also checks that bcd/ovf hold and busy stays high
   task automatic convert(input logic [31:0] v, output int lat, output logic hold_ok);
      @(negedge clk); start = 1'b1; value = v;
      @(negedge clk); start = 1'b0; value = 32'hDEAD_BEEF;
      lat = -1;
      hold_ok = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
         if (!busy || bcd !== prev_bcd || ovf !== prev_ovf) hold_ok = 1'b0;
      end
   endtask

   function automatic int an_idx(input logic [7:0] a);
      an_idx = -1;
      for (int k = 0; k < 8; k++) if (a == ~(8'b1 << k)) an_idx = k;
   endfunction

   initial begin
      int lat;
      logic hold_ok;
      int ndone, first, idx, dwell;
      logic firstchg;
      logic [7:0] pan;
      int dt [4];

      tbl[0] = '{32'd0,          40'h00_0000_0000, 1'b0};
      tbl[1] = '{32'hFFFF_FFFF,  40'h42_9496_7295, 1'b1};
      tbl[2] = '{32'd99_999_999, 40'h00_9999_9999, 1'b0};
      tbl[3] = '{32'd100_000_000,40'h01_0000_0000, 1'b1};
      tbl[4] = '{32'd1205,       40'h00_0000_1205, 1'b0};
      tbl[5] = '{32'd42,         40'h00_0000_0042, 1'b0};
      tbl[6] = '{32'd12345,      40'h00_0001_2345, 1'b0};
      tbl[7] = '{32'd9,          40'h00_0000_0009, 1'b0};
      tbl[8] = '{32'd10,         40'h00_0000_0010, 1'b0};
      tbl[9] = '{32'd5,          40'h00_0000_0005, 1'b0};
      e1205[0] = 7'b0010010; e1205[1] = 7'b1000000;
      e1205[2] = 7'b0100100; e1205[3] = 7'b1111001;
      for (int k = 4; k < 8; k++) e1205[k] = 7'b1111111;

      // reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bcd", bcd, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_an", an, 8'hFE);
      chk("rst_seg", seg, 7'b1000000);
      rst_n = 1'b1;

      // conversion table
      for (int t = 0; t < 10; t++) begin
         convert(tbl[t].v, lat, hold_ok);
         chk($sformatf("lat[%0d]", t), lat, 32);
         chk($sformatf("hold[%0d]", t), hold_ok, 1);
         chk($sformatf("bcd[%0d]", t), bcd, tbl[t].b);
         chk($sformatf("ovf[%0d]", t), ovf, tbl[t].o);
         chk($sformatf("busy_end[%0d]", t), busy, 0);
         @(negedge clk);
         chk($sformatf("done_pulse[%0d]", t), done, 0);
         prev_bcd = tbl[t].b;
         prev_ovf = tbl[t].o;
      end

      // zero: units shows 0, everything else blank
      convert(32'd0, lat, hold_ok);
      chk("z_lat", lat, 32);
      prev_bcd = '0; prev_ovf = 1'b0;
      for (int c = 0; c < 34; c++) begin
         @(negedge clk);
         chk("z_onehot", $countones(~an), 1);
         chk("z_seg", seg, (an == 8'hFE) ? 7'b1000000 : 7'b1111111);
      end

      // overflow: dash everywhere
      convert(32'hFFFF_FFFF, lat, hold_ok);
      chk("o_lat", lat, 32);
      prev_bcd = 40'h42_9496_7295; prev_ovf = 1'b1;
      for (int c = 0; c < 34; c++) begin
         @(negedge clk);
         chk("o_seg", seg, 7'b0111111);
      end

      // scan of 1205: digit order, 4-cycle dwell, wrap 7 -> 0
      convert(32'd1205, lat, hold_ok);
      chk("s_lat", lat, 32);
      prev_bcd = 40'h00_0000_1205; prev_ovf = 1'b0;
      pan = an; dwell = 0; firstchg = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (an != pan) begin
            if (!firstchg) chk("s_dwell", dwell, 4);
            chk("s_step", an, {pan[6:0], pan[7]});
            firstchg = 1'b0;
            dwell = 1;
            pan = an;
         end else begin
            dwell++;
         end
         idx = an_idx(an);
         if (idx < 0) chk("s_onehot", an, 8'hFE);
         else chk($sformatf("s_seg%0d", idx), seg, e1205[idx]);
      end

      // start while busy is ignored
      @(negedge clk); start = 1'b1; value = 32'd1205;
      @(negedge clk); start = 1'b0;
      ndone = 0; first = -1;
      for (int i = 1; i <= 80; i++) begin
         if (i == 4) begin start = 1'b1; value = 32'd7; end
         if (i == 5) start = 1'b0;
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first < 0) first = i;
         end
      end
      chk("ign_first", first, 32);
      chk("ign_count", ndone, 1);
      chk("ign_bcd", bcd, 40'h00_0000_1205);

      // reset mid-conversion aborts, no done
      @(negedge clk); start = 1'b1; value = 32'd12345;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("ab_busy", busy, 0);
      chk("ab_done", done, 0);
      chk("ab_bcd", bcd, 0);
      chk("ab_an", an, 8'hFE);
      rst_n = 1'b1;
      prev_bcd = '0; prev_ovf = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("ab_nodone", ndone, 0);
      convert(32'd12345, lat, hold_ok);
      chk("ab_relat", lat, 32);
      chk("ab_rebcd", bcd, 40'h00_0001_2345);
      prev_bcd = 40'h00_0001_2345;

      // start held high: done every 33 cycles
      @(negedge clk); start = 1'b1; value = 32'd42;
      ndone = 0;
      for (int i = 1; i <= 140; i++) begin
         @(negedge clk);
         if (done) begin
            chk("bb_bcd", bcd, 40'h00_0000_0042);
            if (ndone < 4) dt[ndone] = i;
            ndone++;
         end
      end
      start = 1'b0;
      chk("bb_count", ndone >= 4, 1);
      chk("bb_gap1", dt[1] - dt[0], 33);
      chk("bb_gap2", dt[2] - dt[1], 33);
      chk("bb_gap3", dt[3] - dt[2], 33);
      repeat (40) @(negedge clk);
      chk("bb_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
